alu_writeback_sequencer: RTL and testbench

ALU_WRITEBACK_SEQUENCER -- requirements
Module: alu_writeback_sequencer

---
 rtl/alu_writeback_sequencer.sv | 77 +++++++
 tb/tb_alu_writeback_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_sequencer.sv
// alu_writeback_sequencer: serialises a two-result ALU bundle onto one arbitrated register-file write port.
// Optional ALU_WB_FORWARD_EN adds a combinational forwarding lookup of pending writes.
module alu_writeback_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_y1_select,
  input  logic [3:0]  in_y2_select,
  input  logic [1:0]  in_write,
  input  logic [31:0] in_y1_data,
  input  logic [31:0] in_y2_data,
  output logic        rf_req,
  input  logic        rf_gnt,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] busy_mask,
  output logic        idle
`ifdef ALU_WB_FORWARD_EN
  ,
  input  logic [3:0]  fwd_select,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
`endif
);
  typedef enum logic [1:0] {IDLE, WR_Y1, WR_Y2} state_t;
  typedef struct packed {
    logic        e1;
    logic        e2;
    logic [3:0]  y1;
    logic [3:0]  y2;
    logic [31:0] d1;
    logic [31:0] d2;
  } bundle_t;
  state_t  state_q, state_d;
  bundle_t bundle_q, bundle_d;
  logic e1, e2, e1_eff, acc, last, y1_pend, y2_pend;
  assign e1      = in_write[0] & (in_y1_select != 4'd0);
  assign e2      = in_write[1] & (in_y2_select != 4'd0);
  // A same-destination pair collapses to the Y2 write only.
  assign e1_eff  = e1 & ~(e2 & (in_y1_select == in_y2_select));
  assign idle    = state_q == IDLE;
  assign rf_req  = ~idle;
  assign rf_we   = rf_req & rf_gnt;
  assign last    = rf_we & ((state_q == WR_Y2) | ~bundle_q.e2);
  assign in_ready = idle | last;
  assign acc     = in_valid & in_ready;
  assign y1_pend = state_q == WR_Y1;
  assign y2_pend = rf_req & bundle_q.e2;
  assign rf_waddr = (state_q == WR_Y2) ? bundle_q.y2 : y1_pend ? bundle_q.y1 : 4'd0;
  assign rf_wdata = (state_q == WR_Y2) ? bundle_q.d2 : y1_pend ? bundle_q.d1 : 32'd0;
  assign busy_mask = ({15'd0, y1_pend} << bundle_q.y1) | ({15'd0, y2_pend} << bundle_q.y2);
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    if (acc) begin
      bundle_d = '{e1: e1_eff, e2: e2, y1: in_y1_select, y2: in_y2_select, d1: in_y1_data, d2: in_y2_data};
      state_d  = e1_eff ? WR_Y1 : e2 ? WR_Y2 : IDLE;
    end else if (rf_we) begin
      state_d  = (y1_pend & bundle_q.e2) ? WR_Y2 : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
    end
  end
`ifdef ALU_WB_FORWARD_EN
  assign fwd_hit  = busy_mask[fwd_select] & (fwd_select != 4'd0);
  assign fwd_data = ~fwd_hit ? 32'd0 : (y2_pend & (bundle_q.y2 == fwd_select)) ? bundle_q.d2 : bundle_q.d1;
`endif
endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// tb_alu_writeback_sequencer: vector table plus corner-case sequences, writes checked against a scoreboard queue.
module tb_alu_writeback_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic        reset, in_valid, in_ready, rf_req, rf_gnt, rf_we, idle;
  logic [3:0]  in_y1_select, in_y2_select, rf_waddr;
  logic [1:0]  in_write;
  logic [31:0] in_y1_data, in_y2_data, rf_wdata;
  logic [15:0] busy_mask;
`ifdef ALU_WB_FORWARD_EN
  logic [3:0]  fwd_select;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif
  alu_writeback_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_y1_select(in_y1_select), .in_y2_select(in_y2_select), .in_write(in_write),
    .in_y1_data(in_y1_data), .in_y2_data(in_y2_data), .rf_req(rf_req), .rf_gnt(rf_gnt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_mask(busy_mask), .idle(idle)
`ifdef ALU_WB_FORWARD_EN
    , .fwd_select(fwd_select), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );
  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [3:0] y1, y2; logic [1:0] wr; logic [31:0] d1, d2; logic [15:0] mask; } vec_t;
  wr_t  exp_q[$];
  vec_t vecs[9];
  int n_pass = 0, n_tot = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic expect_bundle(input logic [3:0] y1, y2, input logic [1:0] wr, input logic [31:0] d1, d2);
    logic e1, e2;
    e1 = wr[0] && y1 != 0;
    e2 = wr[1] && y2 != 0;
    if (e1 && e2 && y1 == y2) e1 = 0;
    if (e1) exp_q.push_back('{a: y1, d: d1});
    if (e2) exp_q.push_back('{a: y2, d: d2});
  endtask
  always @(negedge clk) begin
    wr_t w;
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", {28'd0, rf_waddr}, {28'd0, w.a});
        check("wr_data", rf_wdata, w.d);
      end
    end
  end
  task automatic send(input logic [3:0] y1, y2, input logic [1:0] wr, input logic [31:0] d1, d2);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1; in_y1_select = y1; in_y2_select = y2; in_write = wr; in_y1_data = d1; in_y2_data = d2;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin n_tot++; $display("FAIL accept_timeout: got in_ready 0 expected 1"); end
    expect_bundle(y1, y2, wr, d1, d2);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && !idle; i++) @(negedge clk);
    check("drain_idle", {31'd0, idle}, 32'd1);
  endtask
  initial begin
    vecs[0] = '{4'd3,  4'd5, 2'b11, 32'hA0A0_0001, 32'hB0B0_0001, 16'h0028};
    vecs[1] = '{4'd0,  4'd0, 2'b11, 32'h1111_1111, 32'h2222_2222, 16'h0000};
    vecs[2] = '{4'd7,  4'd7, 2'b11, 32'hAAAA_0007, 32'hBBBB_0007, 16'h0080};
    vecs[3] = '{4'd2,  4'd9, 2'b01, 32'h0000_0202, 32'h0000_0909, 16'h0004};
    vecs[4] = '{4'd2,  4'd9, 2'b10, 32'h0000_0202, 32'h0000_0909, 16'h0200};
    vecs[5] = '{4'd15, 4'd1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 16'h8002};
    vecs[6] = '{4'd4,  4'd0, 2'b11, 32'h4444_4444, 32'hDEAD_BEEF, 16'h0010};
    vecs[7] = '{4'd0,  4'd6, 2'b11, 32'hDEAD_BEEF, 32'h6666_6666, 16'h0040};
    vecs[8] = '{4'd3,  4'd4, 2'b00, 32'h3333_3333, 32'h4444_4444, 16'h0000};
    reset = 1; in_valid = 0; rf_gnt = 1; in_y1_select = 0; in_y2_select = 0; in_write = 0;
    in_y1_data = 0; in_y2_data = 0;
`ifdef ALU_WB_FORWARD_EN
    fwd_select = 0;
`endif
    @(posedge clk); @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("rst_rf_req", {31'd0, rf_req}, 0);
    check("rst_rf_we", {31'd0, rf_we}, 0);
    check("rst_busy", {16'd0, busy_mask}, 0);
    check("rst_idle", {31'd0, idle}, 1);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    foreach (vecs[k]) begin
      send(vecs[k].y1, vecs[k].y2, vecs[k].wr, vecs[k].d1, vecs[k].d2);
      @(negedge clk);
      check("vec_busy", {16'd0, busy_mask}, {16'd0, vecs[k].mask});
      check("vec_idle", {31'd0, idle}, {31'd0, vecs[k].mask == 0});
      check("vec_rf_req", {31'd0, rf_req}, {31'd0, vecs[k].mask != 0});
      drain();
    end
    send(4'd3, 4'd5, 2'b11, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    @(negedge clk);
    check("seqa_we1", {31'd0, rf_we}, 1);
    check("seqa_addr1", {28'd0, rf_waddr}, 3);
    check("seqa_busy1", {16'd0, busy_mask}, 32'h28);
    @(negedge clk);
    check("seqa_addr2", {28'd0, rf_waddr}, 5);
    check("seqa_busy2", {16'd0, busy_mask}, 32'h20);
    @(negedge clk);
    check("seqa_busy3", {16'd0, busy_mask}, 0);
    check("seqa_idle", {31'd0, idle}, 1);
    rf_gnt = 0;
    send(4'd1, 4'd2, 2'b11, 32'h0000_1001, 32'h0000_2002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", {31'd0, rf_req}, 1);
      check("stall_addr", {28'd0, rf_waddr}, 1);
      check("stall_ready", {31'd0, in_ready}, 0);
      check("stall_we", {31'd0, rf_we}, 0);
    end
    @(posedge clk); #1; rf_gnt = 1;
    @(negedge clk);
    check("stall_commit_we", {31'd0, rf_we}, 1);
    check("stall_commit_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    in_valid = 1; in_y1_select = 4'd10; in_y2_select = 4'd0; in_write = 2'b01;
    in_y1_data = 32'hC0C0_000A; in_y2_data = 0;
    expect_bundle(4'd10, 4'd0, 2'b01, 32'hC0C0_000A, 0);
    @(negedge clk);
    check("b2b_ready", {31'd0, in_ready}, 1);
    check("b2b_addr_y2", {28'd0, rf_waddr}, 2);
    @(posedge clk); #1; in_valid = 0;
    @(negedge clk);
    check("b2b_req", {31'd0, rf_req}, 1);
    check("b2b_addr", {28'd0, rf_waddr}, 10);
    check("b2b_busy", {16'd0, busy_mask}, 32'h400);
    drain();
    send(4'd11, 4'd12, 2'b11, 32'h0000_0B0B, 32'h0000_0C0C);
    @(posedge clk); #1; rf_gnt = 0; reset = 1;
    @(negedge clk);
    check("rstmid_busy_before", {16'd0, busy_mask}, 32'h1000);
    @(posedge clk); #1; reset = 0; rf_gnt = 1;
    @(negedge clk);
    check("rstmid_req", {31'd0, rf_req}, 0);
    check("rstmid_busy", {16'd0, busy_mask}, 0);
    check("rstmid_idle", {31'd0, idle}, 1);
    check("rstmid_ready", {31'd0, in_ready}, 1);
    check("rstmid_pending", exp_q.size(), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
`ifdef ALU_WB_FORWARD_EN
    rf_gnt = 0;
    send(4'd9, 4'd0, 2'b01, 32'h0000_1234, 0);
    fwd_select = 4'd9; #1;
    check("fwd_hit9", {31'd0, fwd_hit}, 1);
    check("fwd_data9", fwd_data, 32'h1234);
    fwd_select = 4'd0; #1;
    check("fwd_hit0", {31'd0, fwd_hit}, 0);
    rf_gnt = 1;
    drain();
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
